reg_access_unit: RTL and testbench



---
 rtl/reg_access_unit.sv | 165 ++++++++++++++++
 tb/tb_reg_access_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_access_unit.sv
// reg_access_unit
//   Initiator side of the general-purpose register file. It accepts decoded
//   instructions from the IDU, reads operands through the two regfile read
//   ports, and holds back RAW/WAW hazards with a per-register pending-write
//   scoreboard. A writeback arriving in the same cycle is forwarded into the
//   operand. Operands go to the EXU through a single registered valid/ready
//   slot. WBU writebacks drive the regfile write port and are never stalled.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   dec_*              decode request (valid/ready, rs1/rs2/rd, rd write enable)
//   op_*               operand slot towards EXU (valid/ready, src1/src2, rd, rd_wen)
//   wb_*               writeback from WBU (valid/ready, rd, data)
//   rf_raddr1/2        regfile read indices (follow dec_rs1/dec_rs2)
//   rf_rdata1/2        regfile read data (combinational)
//   rf_waddr/wdata/wen regfile write port (written at rising clk)
//   sb_busy            registered scoreboard pending-write bits
module reg_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_LEN  = 5,
  parameter int unsigned N_REG      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [INDEX_LEN-1:0]  dec_rs1,
  input  logic [INDEX_LEN-1:0]  dec_rs2,
  input  logic [INDEX_LEN-1:0]  dec_rd,
  input  logic                  dec_rd_wen,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_src1,
  output logic [DATA_WIDTH-1:0] op_src2,
  output logic [INDEX_LEN-1:0]  op_rd,
  output logic                  op_rd_wen,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [INDEX_LEN-1:0]  wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [INDEX_LEN-1:0]  rf_raddr1,
  output logic [INDEX_LEN-1:0]  rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  output logic [INDEX_LEN-1:0]  rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  rf_wen,
  output logic [N_REG-1:0]      sb_busy
);

  // Registered state
  logic [N_REG-1:0]      busy_q,    busy_d;
  logic                  op_valid_q;
  logic [DATA_WIDTH-1:0] op_src1_q, op_src1_d;
  logic [DATA_WIDTH-1:0] op_src2_q, op_src2_d;
  logic [INDEX_LEN-1:0]  op_rd_q;
  logic                  op_rd_wen_q;

  // Combinational decode-side signals
  logic fwd1, fwd2;
  logic wb_hits_rd;
  logic busy_rs1, busy_rs2, busy_rd;
  logic raw, waw;
  logic slot_free;
  logic dec_fire;
  logic wb_fire;

  // ---------------------------------------------------------------------------
  // Writeback path: straight through to the regfile write port.
  // ---------------------------------------------------------------------------
  assign wb_ready  = !rst;
  assign wb_fire   = wb_valid && wb_ready;
  assign rf_waddr  = wb_rd;
  assign rf_wdata  = wb_data;
  assign rf_wen    = wb_valid && (wb_rd != '0) && !rst;

  // Read indices are the raw decode indices; the regfile answers combinationally.
  assign rf_raddr1 = dec_rs1;
  assign rf_raddr2 = dec_rs2;

  // ---------------------------------------------------------------------------
  // Forwarding, scoreboard lookup and hazard detection
  // ---------------------------------------------------------------------------
  always_comb begin
    fwd1       = wb_valid && (wb_rd == dec_rs1) && (dec_rs1 != '0);
    fwd2       = wb_valid && (wb_rd == dec_rs2) && (dec_rs2 != '0);
    wb_hits_rd = wb_valid && (wb_rd == dec_rd);

    // Index 0 is skipped so x0 never reads as busy, even if N_REG < 2**INDEX_LEN.
    busy_rs1 = 1'b0;
    busy_rs2 = 1'b0;
    busy_rd  = 1'b0;
    for (int unsigned i = 1; i < N_REG; i++) begin
      if (INDEX_LEN'(i) == dec_rs1) busy_rs1 = busy_q[i];
      if (INDEX_LEN'(i) == dec_rs2) busy_rs2 = busy_q[i];
      if (INDEX_LEN'(i) == dec_rd)  busy_rd  = busy_q[i];
    end

    raw = ((dec_rs1 != '0) && busy_rs1 && !fwd1) ||
          ((dec_rs2 != '0) && busy_rs2 && !fwd2);
    waw = dec_rd_wen && (dec_rd != '0) && busy_rd && !wb_hits_rd;
  end

  assign slot_free = !op_valid_q || op_ready;
  assign dec_ready = slot_free && !raw && !waw && !rst;
  assign dec_fire  = dec_valid && dec_ready;

  // Operand selection: x0 reads zero, then same-cycle writeback, then regfile.
  always_comb begin
    op_src1_d = '0;
    op_src2_d = '0;
    if (dec_rs1 != '0) op_src1_d = fwd1 ? wb_data : rf_rdata1;
    if (dec_rs2 != '0) op_src2_d = fwd2 ? wb_data : rf_rdata2;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next state. The set is applied after the clear so that a new
  // producer claiming a register in the same cycle its old value retires keeps
  // the register marked pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 1; i < N_REG; i++) begin
      if (wb_fire && (INDEX_LEN'(i) == wb_rd))
        busy_d[i] = 1'b0;
      if (dec_fire && dec_rd_wen && (INDEX_LEN'(i) == dec_rd))
        busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Registered state: scoreboard and the EXU operand slot
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      op_valid_q  <= 1'b0;
      op_src1_q   <= '0;
      op_src2_q   <= '0;
      op_rd_q     <= '0;
      op_rd_wen_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (dec_fire) begin
        // Reloading while the EXU takes the old entry keeps the slot full.
        op_valid_q  <= 1'b1;
        op_src1_q   <= op_src1_d;
        op_src2_q   <= op_src2_d;
        op_rd_q     <= dec_rd;
        op_rd_wen_q <= dec_rd_wen;
      end else if (op_ready) begin
        op_valid_q  <= 1'b0;
      end
    end
  end

  assign op_valid  = op_valid_q;
  assign op_src1   = op_src1_q;
  assign op_src2   = op_src2_q;
  assign op_rd     = op_rd_q;
  assign op_rd_wen = op_rd_wen_q;
  assign sb_busy   = busy_q;

endmodule

// File: tb/tb_reg_access_unit.sv
// Self-checking bench for reg_access_unit: directed scenarios followed by
// randomized traffic, checked against a register-level reference model with a
// queue-based scoreboard on the operand slot.
module tb_reg_access_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned IL = 5;
  localparam int unsigned NR = 32;

  logic          clk;
  logic          rst;
  logic          dec_valid;
  logic          dec_ready;
  logic [IL-1:0] dec_rs1, dec_rs2, dec_rd;
  logic          dec_rd_wen;
  logic          op_valid;
  logic          op_ready;
  logic [DW-1:0] op_src1, op_src2;
  logic [IL-1:0] op_rd;
  logic          op_rd_wen;
  logic          wb_valid;
  logic          wb_ready;
  logic [IL-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic [IL-1:0] rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic [IL-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_wen;
  logic [NR-1:0] sb_busy;

  reg_access_unit #(.DATA_WIDTH(DW), .INDEX_LEN(IL), .N_REG(NR)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_rd_wen(dec_rd_wen),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_src1(op_src1), .op_src2(op_src2), .op_rd(op_rd), .op_rd_wen(op_rd_wen),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .sb_busy(sb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural regfile. Index 0 returns junk so x0 zeroing inside the DUT is exercised.
  logic [DW-1:0] regs [NR];
  assign rf_rdata1 = (rf_raddr1 == '0) ? 32'hFFFF_FFFF : regs[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == '0) ? 32'hFFFF_FFFF : regs[rf_raddr2];

  typedef struct {
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;
    logic [IL-1:0] rd;
    logic          wen;
  } op_t;

  op_t sbq [$];

  // Reference model: pending-write set plus next-edge updates
  bit            mbusy  [NR];
  bit            p_busy [NR];
  bit            p_push;
  op_t           p_entry;
  bit            p_wb;
  logic [IL-1:0] p_wrd;
  logic [DW-1:0] p_wd;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [NR-1:0] pack_busy();
    logic [NR-1:0] r;
    for (int k = 0; k < int'(NR); k++) r[k] = mbusy[k];
    return r;
  endfunction

  task automatic clear_model();
    sbq.delete();
    for (int k = 0; k < int'(NR); k++) begin
      mbusy[k]  = 1'b0;
      p_busy[k] = 1'b0;
    end
    p_push = 1'b0;
    p_wb   = 1'b0;
  endtask

  task automatic idle_inputs();
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0; dec_rd_wen = 1'b0;
    op_ready  = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_dec_ready"}, 64'(dec_ready), 64'(0));
    chk({tag, "_wb_ready"},  64'(wb_ready),  64'(0));
    chk({tag, "_rf_wen"},    64'(rf_wen),    64'(0));
    chk({tag, "_op_valid"},  64'(op_valid),  64'(0));
    chk({tag, "_op_src1"},   64'(op_src1),   64'(0));
    chk({tag, "_op_src2"},   64'(op_src2),   64'(0));
    chk({tag, "_op_rd"},     64'(op_rd),     64'(0));
    chk({tag, "_op_rd_wen"}, 64'(op_rd_wen), 64'(0));
    chk({tag, "_sb_busy"},   64'(sb_busy),   64'(0));
  endtask

  // One clock cycle: commit the model's previous decisions after the edge,
  // drive new inputs, then check combinational outputs and plan the next edge.
  task automatic cycle(input bit dv, input logic [IL-1:0] r1, input logic [IL-1:0] r2,
                       input logic [IL-1:0] rd, input bit rdw, input bit ordy,
                       input bit wv, input logic [IL-1:0] wrd, input logic [DW-1:0] wd);
    logic [DW-1:0] e1, e2;
    bit stall, erdy, fire;
    @(posedge clk);
    #1;
    if (p_push) sbq.push_back(p_entry);
    mbusy = p_busy;
    if (p_wb) regs[p_wrd] = p_wd;
    dec_valid = dv; dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd; dec_rd_wen = rdw;
    op_ready = ordy; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    #1;
    e1 = (r1 == 0) ? '0 : ((wv && wrd == r1) ? wd : regs[r1]);
    e2 = (r2 == 0) ? '0 : ((wv && wrd == r2) ? wd : regs[r2]);
    stall = 1'b0;
    if (r1 != 0 && mbusy[r1] && !(wv && wrd == r1)) stall = 1'b1;
    if (r2 != 0 && mbusy[r2] && !(wv && wrd == r2)) stall = 1'b1;
    if (rdw && rd != 0 && mbusy[rd] && !(wv && wrd == rd)) stall = 1'b1;
    erdy = (sbq.size() == 0 || ordy) && !stall;
    fire = dv && erdy;

    chk("dec_ready", 64'(dec_ready), 64'(erdy));
    chk("wb_ready",  64'(wb_ready),  64'(1));
    chk("rf_wen",    64'(rf_wen),    64'(wv && wrd != 0));
    if (wv) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(wrd));
      chk("rf_wdata", 64'(rf_wdata), 64'(wd));
    end
    chk("sb_busy", 64'(sb_busy), 64'(pack_busy()));

    p_busy = mbusy;
    if (wv && wrd != 0) p_busy[wrd] = 1'b0;
    if (fire && rdw && rd != 0) p_busy[rd] = 1'b1;
    p_push     = fire;
    p_entry.s1 = e1;
    p_entry.s2 = e2;
    p_entry.rd = rd;
    p_entry.wen = rdw;
    p_wb  = wv && wrd != 0;
    p_wrd = wrd;
    p_wd  = wd;
  endtask

  // Asserts reset between clock edges, checks outputs before any edge arrives.
  task automatic async_reset();
    #1;
    rst = 1'b1;
    clear_model();
    #1;
    reset_checks("async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
  endtask

  // Scoreboard monitor: the slot must hold exactly the oldest accepted op.
  initial begin
    forever begin
      @(negedge clk);
      chk("op_valid", 64'(op_valid), 64'(sbq.size() != 0));
      if (op_valid && sbq.size() != 0) begin
        chk("op_src1",   64'(op_src1),   64'(sbq[0].s1));
        chk("op_src2",   64'(op_src2),   64'(sbq[0].s2));
        chk("op_rd",     64'(op_rd),     64'(sbq[0].rd));
        chk("op_rd_wen", 64'(op_rd_wen), 64'(sbq[0].wen));
        if (op_ready) void'(sbq.pop_front());
      end
    end
  end

  initial begin
    logic [IL-1:0] r1, r2, rd, wrd;
    int base;
    for (int k = 0; k < int'(NR); k++) regs[k] = 32'h11 * k;
    clear_model();
    rst = 1'b1;
    idle_inputs();
    dec_valid = 1'b1; dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_rd = 5'd3; dec_rd_wen = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
    repeat (2) @(posedge clk);
    #2;
    reset_checks("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();

    // Basic issue: operands 0x11/0x22, rd=3 becomes pending
    cycle(1, 5'd1, 5'd2, 5'd3, 1, 1, 0, 5'd0, '0);
    // RAW stall on x3, then released by a same-cycle writeback (forwarded)
    repeat (3) cycle(1, 5'd3, 5'd0, 5'd4, 1, 1, 0, 5'd0, '0);
    cycle(1, 5'd3, 5'd0, 5'd4, 1, 1, 1, 5'd3, 32'hDEAD);
    // x0 source reads zero, x0 destination leaves the scoreboard alone
    cycle(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 5'd0, '0);
    // Writeback to x0 must not write
    cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 5'd0, 32'hBEEF);
    // Back-pressure: slot held for 3 cycles, then reload while draining
    cycle(1, 5'd1, 5'd2, 5'd6, 1, 1, 0, 5'd0, '0);
    repeat (3) cycle(1, 5'd1, 5'd2, 5'd7, 1, 0, 0, 5'd0, '0);
    cycle(1, 5'd1, 5'd2, 5'd7, 1, 1, 0, 5'd0, '0);
    cycle(1, 5'd2, 5'd1, 5'd5, 1, 1, 0, 5'd0, '0);
    // WAW released by writeback to the same rd; set wins over clear
    cycle(1, 5'd1, 5'd2, 5'd5, 1, 1, 1, 5'd5, 32'hCAFE);
    cycle(1, 5'd0, 5'd0, 5'd5, 1, 1, 0, 5'd0, '0);
    // Retire everything, then leave one op in the slot with only x5 pending
    cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 5'd4, 32'h44);
    cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 5'd5, 32'h55);
    cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 5'd6, 32'h66);
    cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 5'd7, 32'h77);
    cycle(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 5'd0, '0);
    cycle(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, '0);
    chk("pre_reset_op_valid", 64'(op_valid), 64'(1));
    chk("pre_reset_sb_busy",  64'(sb_busy),  64'(32'h20));
    async_reset();

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      r1  = 5'($urandom_range(0, 7));
      r2  = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      wrd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        base = int'($urandom_range(0, 7));
        for (int k = 0; k < 8; k++) begin
          if (mbusy[(base + k) % 8]) begin
            wrd = 5'((base + k) % 8);
            break;
          end
        end
      end
      cycle($urandom_range(0, 9) < 7, r1, r2, rd, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, wrd, $urandom);
      if (n == 300) async_reset();
    end

    cycle(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 5'd0, '0);
    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
